// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler : round-robin block/status message sequencer for a byte UART
// Option: `define UART_TX_HEADER_EN to prefix each message with a header byte
// Revision: 1.0
// ============================================================================
module uart_tx_scheduler #(
    parameter logic [7:0] HDR_BLK  = 8'hA5,
    parameter logic [7:0] HDR_STAT = 8'h5A
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blk_valid,
    input  logic [127:0] blk_data,
    output logic         blk_ready,
    input  logic         stat_valid,
    input  logic [7:0]   stat_data,
    output logic         stat_ready,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic         tx_done_flag,
    output logic         busy,
    output logic         msg_done
);

`ifdef UART_TX_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    // One spare byte slot so the header, when enabled, rides at the top of the shifter
    localparam int         SHW       = 136;
    localparam logic [4:0] BLK_LAST  = HDR_EN ? 5'd16 : 5'd15;
    localparam logic [4:0] STAT_LAST = HDR_EN ? 5'd1  : 5'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           state_q;
    logic [SHW-1:0]   shift_q;
    logic [4:0]       cnt_q;
    logic             last_blk_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic             busy_q;
    logic             msg_done_q;

    logic             w_grant_blk;
    logic             w_grant_stat;
    logic [SHW-1:0]   w_load;

    always_comb begin
        w_grant_blk  = 1'b0;
        w_grant_stat = 1'b0;
        if (reset && (state_q == S_IDLE)) begin
            if (blk_valid && (!stat_valid || !last_blk_q)) begin
                w_grant_blk = 1'b1;
            end else if (stat_valid) begin
                w_grant_stat = 1'b1;
            end
        end
        if (w_grant_blk) begin
            w_load = HDR_EN ? {HDR_BLK, blk_data} : {blk_data, 8'h00};
        end else begin
            w_load = HDR_EN ? {HDR_STAT, stat_data, 120'h0} : {stat_data, 128'h0};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= 5'd0;
            last_blk_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            msg_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_grant_blk || w_grant_stat) begin
                        shift_q    <= w_load;
                        tx_data_q  <= w_load[SHW-1 -: 8];
                        cnt_q      <= w_grant_blk ? BLK_LAST : STAT_LAST;
                        last_blk_q <= w_grant_blk;
                        busy_q     <= 1'b1;
                        tx_start_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done_flag) begin
                        if (cnt_q != 5'd0) begin
                            shift_q    <= shift_q << 8;
                            tx_data_q  <= shift_q[SHW-9 -: 8];
                            cnt_q      <= cnt_q - 5'd1;
                            tx_start_q <= 1'b1;
                            state_q    <= S_START;
                        end else begin
                            msg_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign blk_ready  = w_grant_blk;
    assign stat_ready = w_grant_stat;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign msg_done   = msg_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_scheduler : directed self-checking bench for uart_tx_scheduler
// Revision: 1.0
// ============================================================================
module tb_uart_tx_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         stat_valid;
    logic [7:0]   stat_data;
    logic         stat_ready;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_done_flag;
    logic         busy;
    logic         msg_done;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_b [0:16];
    int         n_exp;

    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .blk_valid    (blk_valid),
        .blk_data     (blk_data),
        .blk_ready    (blk_ready),
        .stat_valid   (stat_valid),
        .stat_data    (stat_data),
        .stat_ready   (stat_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_flag (tx_done_flag),
        .busy         (busy),
        .msg_done     (msg_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_blk(input logic [127:0] d);
        n_exp = 0;
`ifdef UART_TX_HEADER_EN
        exp_b[n_exp] = 8'hA5;
        n_exp++;
`endif
        for (int i = 0; i < 16; i++) begin
            exp_b[n_exp] = d[127 - 8*i -: 8];
            n_exp++;
        end
    endtask

    task automatic set_stat(input logic [7:0] d);
        n_exp = 0;
`ifdef UART_TX_HEADER_EN
        exp_b[n_exp] = 8'h5A;
        n_exp++;
`endif
        exp_b[n_exp] = d;
        n_exp++;
    endtask

    // Acts as the transmitter: serves n_srv bytes, holding done off for gap cycles.
    task automatic serve(input int n_srv, input int max_wait, input int gap, input bit skip);
        int k;
        bit stable;
        for (int i = 0; i < n_srv; i++) begin
            if (!(i == 0 && skip)) begin
                k = 0;
                while (!tx_start && k < max_wait) begin
                    @(negedge clk);
                    k++;
                end
                if (tx_start !== 1'b1) begin
                    check("start_timeout", {31'd0, tx_start}, 32'd1);
                    return;
                end
                check($sformatf("byte%0d", i), {24'd0, tx_data}, {24'd0, exp_b[i]});
                check("busy_during", {31'd0, busy}, 32'd1);
                @(negedge clk);
                check("start_one_cycle", {31'd0, tx_start}, 32'd0);
            end else begin
                check($sformatf("byte%0d", i), {24'd0, tx_data}, {24'd0, exp_b[i]});
            end
            stable = 1'b1;
            repeat (gap) begin
                @(negedge clk);
                if (tx_start !== 1'b0 || tx_data !== exp_b[i]) stable = 1'b0;
            end
            check("hold_in_wait", {31'd0, stable}, 32'd1);
            tx_done_flag = 1'b1;
            @(negedge clk);
            tx_done_flag = 1'b0;
            if (i < n_exp - 1) begin
                check("next_start", {31'd0, tx_start}, 32'd1);
                check("no_early_done", {31'd0, msg_done}, 32'd0);
            end else begin
                check("msg_done", {31'd0, msg_done}, 32'd1);
                check("busy_clear", {31'd0, busy}, 32'd0);
            end
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_msg_done"}, {31'd0, msg_done}, 32'd0);
        check({tag, "_blk_ready"}, {31'd0, blk_ready}, 32'd0);
        check({tag, "_stat_ready"}, {31'd0, stat_ready}, 32'd0);
    endtask

    initial begin
        bit quiet;
        reset        = 1'b0;
        tx_done_flag = 1'b0;
        blk_valid    = 1'b1;
        stat_valid   = 1'b1;
        blk_data     = 128'h00112233445566778899AABBCCDDEEFF;
        stat_data    = 8'hC3;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");

        // Tie from reset: block first
        reset = 1'b1;
        #1;
        check("tie_blk_ready", {31'd0, blk_ready}, 32'd1);
        check("tie_stat_ready", {31'd0, stat_ready}, 32'd0);
        @(negedge clk);
        blk_valid = 1'b0;
        set_blk(blk_data);
        serve(n_exp, 0, 3, 1'b0);
        check("stat_ready_in_done", {31'd0, stat_ready}, 32'd1);
        check("blk_ready_in_done", {31'd0, blk_ready}, 32'd0);

        // Status granted in the msg_done cycle; block re-offered alongside a new status
        @(negedge clk);
        blk_valid = 1'b1;
        blk_data  = 128'hFEDCBA98765432100123456789ABCDEF;
        set_stat(8'hC3);
        check("no_ready_while_busy", {31'd0, stat_ready | blk_ready}, 32'd0);
        serve(n_exp, 0, 2, 1'b0);
        check("tie2_blk_ready", {31'd0, blk_ready}, 32'd1);
        check("tie2_stat_ready", {31'd0, stat_ready}, 32'd0);
        blk_valid  = 1'b0;
        stat_valid = 1'b0;
        @(negedge clk);
        check("withdraw_busy", {31'd0, busy}, 32'd0);
        check("withdraw_start", {31'd0, tx_start}, 32'd0);
        check("done_pulse_width", {31'd0, msg_done}, 32'd0);

        // Spurious done in IDLE and START, then a long handshake hold
        tx_done_flag = 1'b1;
        @(negedge clk);
        tx_done_flag = 1'b0;
        check("spur_idle_busy", {31'd0, busy}, 32'd0);
        check("spur_idle_done", {31'd0, msg_done}, 32'd0);
        stat_data  = 8'h3C;
        stat_valid = 1'b1;
        set_stat(8'h3C);
        @(negedge clk);
        stat_valid = 1'b0;
        check("stat_start", {31'd0, tx_start}, 32'd1);
        check("stat_first", {24'd0, tx_data}, {24'd0, exp_b[0]});
        tx_done_flag = 1'b1;
        @(negedge clk);
        tx_done_flag = 1'b0;
        check("spur_start_done", {31'd0, msg_done}, 32'd0);
        check("spur_start_busy", {31'd0, busy}, 32'd1);
        check("spur_start_pulse", {31'd0, tx_start}, 32'd0);
        serve(n_exp, 0, 1000, 1'b1);
        @(negedge clk);
        check("stat_done_width", {31'd0, msg_done}, 32'd0);

        // Reset after the 5th byte's tx_start
        blk_data  = 128'h0123456789ABCDEFFEDCBA9876543210;
        blk_valid = 1'b1;
        set_blk(blk_data);
        @(negedge clk);
        blk_valid = 1'b0;
        serve(4, 0, 2, 1'b0);
        check("byte5_data", {24'd0, tx_data}, {24'd0, exp_b[4]});
        reset     = 1'b0;
        blk_valid = 1'b1;
        @(negedge clk);
        check_reset_outs("midrst");
        reset     = 1'b1;
        blk_valid = 1'b0;
        quiet     = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (msg_done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("after_rst_quiet", {31'd0, quiet}, 32'd1);
        stat_data  = 8'h81;
        stat_valid = 1'b1;
        set_stat(8'h81);
        @(negedge clk);
        stat_valid = 1'b0;
        serve(n_exp, 0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

- Sequences multi-byte messages onto the single-byte UART transmitter, which exposes `tx_start`, `d_in[7:0]` and `tx_done_flag`.
- Shares that transmitter between two requesters:
  - a 128-bit block source (AES ciphertext, 16 bytes);
  - an 8-bit status source.
- Arbitrates round-robin, captures the winning message, and issues one byte per transmitter handshake until the message is sent.

## Interface
Parameters:
- `HDR_BLK`, 8'hA5: header byte for block messages (used only with header feature).
- `HDR_STAT`, 8'h5A: header byte for status messages (used only with header feature).

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `blk_valid` input 1: block message offered; held with `blk_data` until `blk_ready`.
- `blk_data` input 128: block payload; byte [127:120] is sent first.
- `blk_ready` output 1: block accepted at this edge.
- `stat_valid` input 1: status byte offered; held with `stat_data` until `stat_ready`.
- `stat_data` input 8: status payload.
- `stat_ready` output 1: status accepted at this edge.
- `tx_start` output 1: one-cycle start pulse to the transmitter.
- `tx_data` output 8: byte to the transmitter `d_in`; stable from the `tx_start` cycle until `tx_done_flag`.
- `tx_done_flag` input 1: transmitter byte-complete pulse.
- `busy` output 1: high from acceptance until the message completes.
- `msg_done` output 1: one-cycle pulse after the last byte's `tx_done_flag`.

## Operation
- States: IDLE, START, WAIT.
- IDLE:
  - `blk_ready`/`stat_ready` are combinational grants, high only in IDLE.
  - Only one requester valid → grant it.
  - Both valid → grant the one not granted last (`last_grant`).
  - `last_grant` resets to status, so the first tie goes to block.
- On grant edge:
  - Load the shift register with the payload: block is 128 bits MSB-first; status is the byte in [127:120].
  - Load the byte counter (5 bits) with message length − 1: 15 for block, 0 for status.
  - Update `last_grant`, set `busy`, then go to START.
- START:
  - `tx_start`=1 and `tx_data`=shift[127:120] for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold `tx_data`.
  - On `tx_done_flag`=1 with counter ≠ 0: shift left 8, decrement counter, go to START.
  - On `tx_done_flag`=1 with counter = 0: pulse `msg_done`, clear `busy`, go to IDLE.
- `tx_done_flag` in IDLE or START is ignored.
- Valid without ready: the request is not consumed. Dropping `valid` before `ready` withdraws the request with no side effect.
- Reset values:
  - state IDLE; `tx_start`, `msg_done`, `busy`, `blk_ready`, `stat_ready` = 0;
  - `tx_data` = 8'h00; counter 0; shift register 0; `last_grant` = status.
- Reset asserted mid-message aborts immediately. The remaining bytes are discarded and no `msg_done` is issued. The transmitter shares the same reset.

## Timing
- Grant at edge k:
  - `tx_start`=1 with first byte in cycle k+1;
  - `tx_start`=0 from cycle k+2.
- `tx_done_flag` sampled at edge m:
  - next byte's `tx_start` is in cycle m+1; or
  - `msg_done`=1 in cycle m+1, with ready possible again in cycle m+1 (IDLE).
- The single-cycle gap satisfies the transmitter's requirement that its state has returned to idle before `tx_start` is seen.
- Message duration, with B = byte count and T = transmitter byte time: B·T + B cycles of scheduler overhead.
- Back-to-back messages: the new grant can occur in the same cycle `msg_done` is high.

## Configuration
- `UART_TX_HEADER_EN` defined:
  - every message is prefixed by a header byte: `HDR_BLK` for block, `HDR_STAT` for status;
  - lengths become 17 and 2 bytes (counter loads 16 / 1);
  - the header is the first byte after grant.
- Undefined: no header; lengths are 16 and 1.

## Test plan
- Status only:
  - Stimulus: `stat_valid`=1, `stat_data`=8'h3C.
  - Response: grant; one `tx_start` with `tx_data`=8'h3C; `msg_done` one cycle after `tx_done_flag`.
  - With `UART_TX_HEADER_EN`: 8'h5A then 8'h3C.
- Block:
  - Stimulus: `blk_data`=128'h00112233445566778899AABBCCDDEEFF.
  - Response: exactly 16 `tx_start` pulses carrying 00,11,…,FF in order, each one cycle after the previous `tx_done_flag`; `busy` high throughout.
- Tie:
  - Stimulus: both valid from reset.
  - Response: block granted first; status granted in the `msg_done` cycle; with both still valid afterwards, the next tie goes to block.
- Spurious done:
  - Stimulus: `tx_done_flag` pulses in IDLE and in the START cycle.
  - Response: no state change, no byte skipped, no `msg_done`.
- Reset mid-block:
  - Stimulus: `reset`=0 after the 5th byte's `tx_start`.
  - Response: next cycle all outputs are at reset values, no `msg_done`; a new status request then sends normally.
- Handshake hold:
  - Stimulus: `tx_done_flag` delayed 1000 cycles.
  - Response: `tx_data` stable and `tx_start` low throughout WAIT.
